// File: rtl/wb_select_stage_if.sv
// Bundle between the issue stage and the writeback-select stage: instruction in,
// source data in, register-file write and status out.
interface wb_select_stage_if #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 23,
   parameter int NSRC   = 9,
   parameter int SEL_W  = 4,
   parameter int ADDR_W = 5
);
   logic                   in_valid;
   logic                   in_ready;
   logic [SEL_W-1:0]       sel;
   logic [IMM_W-1:0]       imm;
   logic                   imm_sext;
   logic [ADDR_W-1:0]      dest;
   logic                   we_in;
   logic [NSRC*DATA_W-1:0] src_data;
   logic [NSRC-1:0]        src_vld;
   logic                   flush;
   logic                   wb_valid;
   logic                   wb_we;
   logic [ADDR_W-1:0]      wb_addr;
   logic [DATA_W-1:0]      wb_data;
   logic                   stall;
   logic                   err_timeout;

   modport master (
      output in_valid, sel, imm, imm_sext, dest, we_in, src_data, src_vld, flush,
      input  in_ready, wb_valid, wb_we, wb_addr, wb_data, stall, err_timeout
   );

   modport slave (
      input  in_valid, sel, imm, imm_sext, dest, we_in, src_data, src_vld, flush,
      output in_ready, wb_valid, wb_we, wb_addr, wb_data, stall, err_timeout
   );
endinterface

// File: rtl/wb_select_stage.sv
// Registered writeback-select stage: picks a result source or the extended immediate,
// stalls while the chosen source is not valid, and issues one register-file write.
//
// state  | meaning
// S_IDLE | accepting instructions; writes the following cycle when the source is ready
// S_WAIT | holding a latched instruction until its source is valid, flushed or timed out
module wb_select_stage #(
   parameter int DATA_W       = 32,
   parameter int IMM_W        = 23,
   parameter int NSRC         = 9,
   parameter int SEL_W        = 4,
   parameter int ADDR_W       = 5,
   parameter int TIMEOUT      = 255,
   parameter int ZERO_PROTECT = 1
) (
   input logic               clk,
   input logic               rst_n,
   wb_select_stage_if.slave  bus
);
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [SEL_W-1:0]  lat_sel, lat_sel_nxt;
   logic [IMM_W-1:0]  lat_imm, lat_imm_nxt;
   logic              lat_sext, lat_sext_nxt;
   logic [ADDR_W-1:0] lat_dest, lat_dest_nxt;
   logic              lat_we, lat_we_nxt;
   logic              wb_valid_r, wb_valid_nxt;
   logic              wb_we_r, wb_we_nxt;
   logic [ADDR_W-1:0] wb_addr_r, wb_addr_nxt;
   logic [DATA_W-1:0] wb_data_r, wb_data_nxt;
   logic              err_r, err_nxt;

   logic [SEL_W-1:0]  eff_sel;
   logic [IMM_W-1:0]  eff_imm;
   logic              eff_sext;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] src_val;
   logic              src_rdy;
   logic              accept;
   logic              tmo_hit;

   // One resolver serves both the live instruction (IDLE) and the latched one (WAIT).
   assign eff_sel  = (state == S_WAIT) ? lat_sel  : bus.sel;
   assign eff_imm  = (state == S_WAIT) ? lat_imm  : bus.imm;
   assign eff_sext = (state == S_WAIT) ? lat_sext : bus.imm_sext;

   generate
      if (IMM_W >= DATA_W) begin : g_imm_trunc
         assign imm_ext = eff_imm[DATA_W-1:0];
      end else begin : g_imm_ext
         assign imm_ext = {{(DATA_W-IMM_W){eff_sext & eff_imm[IMM_W-1]}}, eff_imm};
      end
   endgenerate

   always_comb begin
      src_val = '0;
      src_rdy = 1'b1;
      if (eff_sel == SEL_W'(NSRC)) begin
         src_val = imm_ext;
      end else begin
         for (int k = 0; k < NSRC; k++) begin
            if (eff_sel == SEL_W'(k)) begin
               src_val = bus.src_data[k*DATA_W +: DATA_W];
               src_rdy = bus.src_vld[k];
            end
         end
      end
   end

   assign bus.in_ready    = (state == S_IDLE) && !bus.flush;
   assign bus.stall       = (state == S_WAIT);
   assign bus.wb_valid    = wb_valid_r;
   assign bus.wb_we       = wb_we_r;
   assign bus.wb_addr     = wb_addr_r;
   assign bus.wb_data     = wb_data_r;
   assign bus.err_timeout = err_r;

   assign accept  = bus.in_valid && bus.in_ready;
   assign tmo_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      lat_sel_nxt  = lat_sel;
      lat_imm_nxt  = lat_imm;
      lat_sext_nxt = lat_sext;
      lat_dest_nxt = lat_dest;
      lat_we_nxt   = lat_we;
      wb_valid_nxt = 1'b0;
      wb_we_nxt    = 1'b0;
      wb_addr_nxt  = wb_addr_r;
      wb_data_nxt  = wb_data_r;
      err_nxt      = err_r;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               if (src_rdy) begin
                  wb_valid_nxt = 1'b1;
                  wb_addr_nxt  = bus.dest;
                  wb_data_nxt  = src_val;
                  wb_we_nxt    = bus.we_in && !((ZERO_PROTECT != 0) && (bus.dest == '0));
               end else begin
                  lat_sel_nxt  = bus.sel;
                  lat_imm_nxt  = bus.imm;
                  lat_sext_nxt = bus.imm_sext;
                  lat_dest_nxt = bus.dest;
                  lat_we_nxt   = bus.we_in;
                  cnt_nxt      = '0;
                  state_nxt    = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // Flush outranks both arriving data and timeout expiry.
            if (bus.flush) begin
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
            end else if (src_rdy || tmo_hit) begin
               wb_valid_nxt = 1'b1;
               wb_addr_nxt  = lat_dest;
               wb_data_nxt  = src_rdy ? src_val : '0;
               wb_we_nxt    = lat_we && !((ZERO_PROTECT != 0) && (lat_dest == '0));
               err_nxt      = err_r || !src_rdy;
               cnt_nxt      = '0;
               state_nxt    = S_IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         lat_sel    <= '0;
         lat_imm    <= '0;
         lat_sext   <= 1'b0;
         lat_dest   <= '0;
         lat_we     <= 1'b0;
         wb_valid_r <= 1'b0;
         wb_we_r    <= 1'b0;
         wb_addr_r  <= '0;
         wb_data_r  <= '0;
         err_r      <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         lat_sel    <= lat_sel_nxt;
         lat_imm    <= lat_imm_nxt;
         lat_sext   <= lat_sext_nxt;
         lat_dest   <= lat_dest_nxt;
         lat_we     <= lat_we_nxt;
         wb_valid_r <= wb_valid_nxt;
         wb_we_r    <= wb_we_nxt;
         wb_addr_r  <= wb_addr_nxt;
         wb_data_r  <= wb_data_nxt;
         err_r      <= err_nxt;
      end
   end
endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: directed scenarios plus random traffic, all checked
// against a transaction-level reference model of the writeback-select rules.
module tb_wb_select_stage;
   localparam int DATA_W = 32, IMM_W = 23, NSRC = 9, SEL_W = 4, ADDR_W = 5;
   localparam int TIMEOUT = 8, ZERO_PROTECT = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_select_stage_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .NSRC(NSRC), .SEL_W(SEL_W),
                        .ADDR_W(ADDR_W)) bus ();

   wb_select_stage #(.DATA_W(DATA_W), .IMM_W(IMM_W), .NSRC(NSRC), .SEL_W(SEL_W),
                     .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .ZERO_PROTECT(ZERO_PROTECT))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int total = 0;
   int bad = 0;

   logic [DATA_W-1:0] slot [NSRC];
   logic [NSRC-1:0]   vld;

   // reference model: a pending instruction plus the visible writeback registers
   bit                m_pend;
   logic [SEL_W-1:0]  p_sel;
   logic [IMM_W-1:0]  p_imm;
   logic              p_sext;
   logic [ADDR_W-1:0] p_dest;
   logic              p_we;
   int                m_waited;
   logic              m_valid, m_we, m_err;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;

   task automatic check(input string tag, input logic [DATA_W-1:0] got,
                        input logic [DATA_W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W:0] resolve(input logic [SEL_W-1:0] s,
                                              input logic [IMM_W-1:0] im, input logic sx);
      int unsigned si;
      longint v;
      si = s;
      if (si < NSRC) return {vld[si], slot[si]};
      if (si == NSRC) begin
         v = longint'(im);
         if (sx && im[IMM_W-1]) v = v - (longint'(1) << IMM_W);
         return {1'b1, v[DATA_W-1:0]};
      end
      return {1'b1, {DATA_W{1'b0}}};
   endfunction

   task automatic model_write(input logic [ADDR_W-1:0] d, input logic w,
                              input logic [DATA_W-1:0] v);
      m_valid = 1'b1;
      m_addr  = d;
      m_data  = v;
      m_we    = w && !(ZERO_PROTECT != 0 && d == 0);
   endtask

   task automatic model_reset();
      m_pend = 0; m_waited = 0;
      m_valid = 0; m_we = 0; m_err = 0; m_addr = '0; m_data = '0;
   endtask

   task automatic model_edge();
      logic [DATA_W:0] r;
      m_valid = 1'b0;
      m_we    = 1'b0;
      if (!m_pend) begin
         if (bus.in_valid && !bus.flush) begin
            r = resolve(bus.sel, bus.imm, bus.imm_sext);
            if (r[DATA_W]) model_write(bus.dest, bus.we_in, r[DATA_W-1:0]);
            else begin
               m_pend = 1; m_waited = 0;
               p_sel = bus.sel; p_imm = bus.imm; p_sext = bus.imm_sext;
               p_dest = bus.dest; p_we = bus.we_in;
            end
         end
      end else if (bus.flush) begin
         m_pend = 0;
      end else begin
         r = resolve(p_sel, p_imm, p_sext);
         if (r[DATA_W]) begin
            model_write(p_dest, p_we, r[DATA_W-1:0]);
            m_pend = 0;
         end else if (m_waited + 1 == TIMEOUT) begin
            model_write(p_dest, p_we, '0);
            m_err = 1; m_pend = 0;
         end else begin
            m_waited++;
         end
      end
   endtask

   task automatic drive_src();
      for (int k = 0; k < NSRC; k++) bus.src_data[k*DATA_W +: DATA_W] = slot[k];
      bus.src_vld = vld;
   endtask

   task automatic step(input string tag);
      drive_src();
      #1;
      check({tag, ":in_ready"}, bus.in_ready, !m_pend && !bus.flush);
      check({tag, ":stall"}, bus.stall, m_pend);
      model_edge();
      @(posedge clk);
      #1;
      check({tag, ":wb_valid"}, bus.wb_valid, m_valid);
      check({tag, ":wb_we"}, bus.wb_we, m_we);
      check({tag, ":wb_addr"}, bus.wb_addr, m_addr);
      check({tag, ":wb_data"}, bus.wb_data, m_data);
      check({tag, ":err"}, bus.err_timeout, m_err);
   endtask

   task automatic set_instr(input logic v, input int s, input logic [ADDR_W-1:0] d,
                            input logic w);
      bus.in_valid = v;
      bus.sel      = SEL_W'(s);
      bus.dest     = d;
      bus.we_in    = w;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ":rst_valid"}, bus.wb_valid, 1'b0);
      check({tag, ":rst_we"}, bus.wb_we, 1'b0);
      check({tag, ":rst_addr"}, bus.wb_addr, '0);
      check({tag, ":rst_data"}, bus.wb_data, '0);
      check({tag, ":rst_stall"}, bus.stall, 1'b0);
      check({tag, ":rst_err"}, bus.err_timeout, 1'b0);
   endtask

   int n_stall;

   initial begin
      for (int k = 0; k < NSRC; k++) slot[k] = DATA_W'(32'h1000_0000 + k);
      vld = '1;
      set_instr(1'b0, 0, '0, 1'b0);
      bus.imm = '0; bus.imm_sext = 1'b0; bus.flush = 1'b0;
      drive_src();
      model_reset();
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // basic accept and back-to-back throughput
      slot[0] = 32'h0000_1234;
      set_instr(1'b1, 0, 5'd3, 1'b1);
      step("first");
      check("first_data", bus.wb_data, 32'h0000_1234);
      check("first_addr", bus.wb_addr, 32'd3);
      slot[0] = 32'h0000_5678;
      set_instr(1'b1, 0, 5'd4, 1'b1);
      step("b2b");
      check("b2b_valid", bus.wb_valid, 1'b1);

      // immediate extension
      bus.imm = 23'h40_0000; bus.imm_sext = 1'b1;
      set_instr(1'b1, NSRC, 5'd7, 1'b1);
      step("imm_sext");
      check("imm_sext_data", bus.wb_data, 32'hFFC0_0000);
      bus.imm_sext = 1'b0;
      step("imm_zext");
      check("imm_zext_data", bus.wb_data, 32'h0040_0000);
      set_instr(1'b1, 12, 5'd8, 1'b1);
      step("sel_over");
      check("sel_over_data", bus.wb_data, 32'h0);

      // stall until source 1 becomes valid
      vld[1] = 1'b0;
      set_instr(1'b1, 1, 5'd9, 1'b1);
      step("wait_acc");
      set_instr(1'b1, 0, 5'd10, 1'b1);
      for (int i = 0; i < 3; i++) step("wait_hold");
      check("wait_stall", bus.stall, 1'b1);
      vld[1] = 1'b1; slot[1] = 32'hDEAD_BEEF;
      step("wait_done");
      check("wait_data", bus.wb_data, 32'hDEAD_BEEF);
      check("wait_addr", bus.wb_addr, 32'd9);
      check("wait_stall_drop", bus.stall, 1'b0);

      // timeout: source never valid
      vld[2] = 1'b0;
      set_instr(1'b1, 2, 5'd11, 1'b1);
      step("tmo_acc");
      set_instr(1'b0, 0, 5'd0, 1'b0);
      n_stall = 0;
      for (int i = 0; i < 20 && !bus.wb_valid; i++) begin
         if (bus.stall) n_stall++;
         step("tmo");
      end
      check("tmo_stall_cycles", n_stall, TIMEOUT);
      check("tmo_valid", bus.wb_valid, 1'b1);
      check("tmo_data", bus.wb_data, 32'h0);
      check("tmo_err", bus.err_timeout, 1'b1);
      for (int i = 0; i < 20; i++) step("tmo_after");
      check("tmo_err_sticky", bus.err_timeout, 1'b1);
      vld[2] = 1'b1;

      // flush beats simultaneous src_vld
      vld[3] = 1'b0;
      set_instr(1'b1, 3, 5'd12, 1'b1);
      step("fl_acc");
      step("fl_wait");
      bus.flush = 1'b1; vld[3] = 1'b1;
      step("fl_hit");
      check("fl_no_valid", bus.wb_valid, 1'b0);
      bus.flush = 1'b0;
      set_instr(1'b0, 0, 5'd0, 1'b0);
      step("fl_after");
      check("fl_ready", bus.in_ready, 1'b1);

      // zero-register protection
      set_instr(1'b1, 0, 5'd0, 1'b1);
      step("zero");
      check("zero_valid", bus.wb_valid, 1'b1);
      check("zero_we", bus.wb_we, 1'b0);

      // reset in the middle of WAIT
      vld[4] = 1'b0;
      set_instr(1'b1, 4, 5'd13, 1'b1);
      step("mid_acc");
      step("mid_wait");
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      vld[4] = 1'b1;
      set_instr(1'b0, 0, 5'd0, 1'b0);
      step("midrst_after");

      // random traffic
      for (int i = 0; i < 800; i++) begin
         for (int k = 0; k < NSRC; k++) begin
            slot[k] = $urandom;
            vld[k]  = ($urandom_range(0, 9) < 6);
         end
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.sel      = SEL_W'($urandom_range(0, 15));
         bus.imm      = IMM_W'($urandom);
         bus.imm_sext = $urandom_range(0, 1);
         bus.dest     = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
         bus.we_in    = $urandom_range(0, 1);
         bus.flush    = ($urandom_range(0, 19) == 0);
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Parametrised, registered writeback-select stage for the processor datapath.
- Selects one of NSRC result sources or the extended immediate and presents one register-file write per instruction.
- Stalls the front end when the selected source (memory read, IN peripheral, BIOS) is not yet valid.
- A timeout, a flush path and zero-register protection complete the block.

Parameters:
DATA_W, 32, width of every source and of wb_data
IMM_W, 23, width of the immediate field
NSRC, 9, number of data sources; sel values 0..NSRC-1
SEL_W, 4, width of sel; must hold the value NSRC
ADDR_W, 5, register destination address width
TIMEOUT, 255, maximum WAIT cycles before forced zero write; 0 disables the timeout
ZERO_PROTECT, 1, when 1, writes to address 0 are suppressed

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept an instruction this cycle
sel  in  SEL_W  source select
imm  in  IMM_W  immediate field
imm_sext  in  1  1 = sign-extend imm, 0 = zero-extend imm
dest  in  ADDR_W  destination register
we_in  in  1  instruction writes a register
src_data  in  NSRC*DATA_W  flattened sources; slot k occupies bits [k*DATA_W +: DATA_W]
src_vld  in  NSRC  per-source data-valid
flush  in  1  discard the pending instruction
wb_valid  out  1  one-cycle writeback strobe
wb_we  out  1  register-file write enable
wb_addr  out  ADDR_W  write address
wb_data  out  DATA_W  write data
stall  out  1  high while in WAIT
err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0): state IDLE; wb_valid=0, wb_we=0, wb_addr=0, wb_data=0, stall=0, err_timeout=0, wait counter=0.
- Source resolution:
  - sel<NSRC: value = slot sel; ready = src_vld[sel].
  - sel==NSRC: value = imm extended to DATA_W per imm_sext; always ready.
  - sel>NSRC: value = 0; always ready.
- in_ready = (state==IDLE) && !flush. An instruction is accepted when in_valid && in_ready.
- IDLE:
  - Accept with source ready: on the next edge, register wb_data=value, wb_addr=dest, wb_we=we_in && !(ZERO_PROTECT && dest==0), wb_valid=1. Latency 1 cycle; throughput 1 instruction per cycle.
  - Accept with source not ready: latch sel, dest, we_in, imm, imm_sext; go to WAIT; counter=0; wb_valid=0.
  - No accept: wb_valid=0, wb_we=0; wb_addr and wb_data hold.
- WAIT (stall=1, in_ready=0):
  - Each cycle, re-evaluate the latched sel against the live src_data/src_vld.
  - src_vld[latched sel]=1: write as in IDLE on that edge, return to IDLE.
  - Otherwise counter increments.
  - TIMEOUT!=0 and counter reaches TIMEOUT-1 without valid data: wb_valid=1, wb_data=0, wb_we per the latched fields; err_timeout set; return to IDLE. Exactly TIMEOUT stall cycles occur.
- flush:
  - In WAIT: return to IDLE at the next edge, wb_valid=0, counter cleared.
  - flush has priority over simultaneous src_vld and over timeout expiry.
  - In IDLE it blocks acceptance.
- wb_valid is a single-cycle pulse; wb_we is only ever high while wb_valid is high.
- err_timeout clears only on reset.
- Reset asserted mid-WAIT aborts the instruction with no write.
- Immediate extension when IMM_W >= DATA_W: truncate to the low DATA_W bits.

Test Plan:
- Reset release; in_valid=1, sel=0, slot0=32'h0000_1234, dest=3, we_in=1 -> next cycle wb_valid=1, wb_we=1, wb_addr=3, wb_data=32'h0000_1234; in_ready stays 1 for back-to-back accepts.
- sel=NSRC, imm=23'h40_0000, imm_sext=1 -> wb_data=32'hFFC0_0000; same with imm_sext=0 -> 32'h0040_0000.
- sel=1 with src_vld[1]=0 for 4 cycles, then 1 with slot1=32'hDEAD_BEEF -> stall=1 and in_ready=0 for 4 cycles; wb_valid in the 5th cycle with 32'hDEAD_BEEF; stall drops.
- TIMEOUT=8, src_vld never asserted -> 8 stall cycles, then wb_valid=1, wb_data=0, err_timeout=1 and still 1 after 20 further cycles.
- In WAIT, assert flush and src_vld in the same cycle -> no wb_valid pulse, returns to IDLE, in_ready=1 the following cycle.
- dest=0, we_in=1, ZERO_PROTECT=1 -> wb_valid=1, wb_we=0; rst_n pulsed low mid-WAIT -> all outputs 0 immediately, no write.
